mux_rr_arbiter: RTL and testbench



---
 rtl/mux_arb_pkg.sv | 41 ++++
 rtl/mux_rr_arbiter_rr_pick.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 115 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Types and helper functions for the round-robin datapath arbiter.
package mux_arb_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam int MAX_N  = 16;
    localparam int MAX_PW = 4;

    typedef struct packed {
        logic              found;
        logic [MAX_PW-1:0] idx;
    } pick_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [MAX_PW-1:0] idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First set bit scanning ptr, ptr+1, ... wrapping at n (n may be non-power-of-2).
    function automatic pick_t rr_select(input logic [MAX_N-1:0] req,
                                        input logic [MAX_PW-1:0] ptr,
                                        input int n);
        pick_t p;
        int    k;
        p = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (i < n && !p.found) begin
                k = int'(ptr) + i;
                if (k >= n) k = k - n;
                if (req[k[MAX_PW-1:0]]) begin
                    p.found = 1'b1;
                    p.idx   = k[MAX_PW-1:0];
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin winner selection starting at ptr.
module rr_pick
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          found
);

    pick_t pick;

    always_comb begin
        pick   = rr_select(MAX_N'(req), MAX_PW'(ptr), N);
        winner = PW'(pick.idx);
        found  = pick.found;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// N:1 round-robin arbiter with packet lock feeding a single registered output beat.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8,
    localparam int PW = $clog2(N)
) (
    input  logic           clk,
    input  logic           clrn,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   last,
    input  logic [N*W-1:0] data,
    output logic [N-1:0]   ack,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   own;
    logic [PW-1:0]   winner;
    logic            found;
    logic            free;
    logic            acc;
    logic [PW-1:0]   acc_idx;
    logic [W-1:0]    acc_data;
    logic            acc_last;

    function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] i);
        return (int'(i) == N - 1) ? '0 : i + 1'b1;
    endfunction

    rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .found  (found)
    );

    assign free     = !out_valid || out_ready;
    assign acc_data = data[int'(acc_idx)*W +: W];
    assign acc_last = last[acc_idx];

    always_ff @(posedge clk) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (acc && !acc_last) state_nxt = BUSY;
            BUSY: if (acc && acc_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // While locked only the owner may be accepted; others are invisible.
    always_comb begin
        ack     = '0;
        acc     = 1'b0;
        acc_idx = winner;
        if (clrn && free) begin
            case (state)
                IDLE: acc = found;
                BUSY: begin
                    acc_idx = own;
                    acc     = req[own];
                end
                default: acc = 1'b0;
            endcase
        end
        if (acc) ack[acc_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            ptr   <= '0;
            own   <= '0;
            grant <= '0;
            busy  <= 1'b0;
        end else if (acc) begin
            if (acc_last) begin
                ptr   <= inc_wrap(acc_idx);
                grant <= '0;
                busy  <= 1'b0;
            end else if (state == IDLE) begin
                own   <= acc_idx;
                grant <= N'(onehot(MAX_PW'(acc_idx)));
                busy  <= 1'b1;
            end
        end
    end

    // Output beat: load on accept, drop valid when drained with nothing new, hold on stall.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (free) begin
            out_valid <= acc;
            if (acc) begin
                out_data <= acc_data;
                out_last <= acc_last;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed vector bench for mux_rr_arbiter (N=4, W=8).
module tb_mux_rr_arbiter;

    logic        clk;
    logic        clrn;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [3:0]  grant;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mux_rr_arbiter #(.N(4), .W(8)) dut (
        .clk       (clk),
        .clrn      (clrn),
        .req       (req),
        .last      (last),
        .data      (data),
        .ack       (ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        clrn;
        logic [3:0]  req;
        logic [3:0]  last;
        logic        rdy;
        logic [31:0] data;
        logic [3:0]  ack;
        logic        ov;
        logic [7:0]  od;
        logic        ol;
        logic [3:0]  g;
        logic        b;
    } vec_t;

    localparam int NV = 35;
    vec_t vt[NV];

    function automatic vec_t mk(input logic c, input logic [3:0] r, input logic [3:0] l,
                                input logic rd, input logic [31:0] d, input logic [3:0] a,
                                input logic ov, input logic [7:0] od, input logic ol,
                                input logic [3:0] g, input logic b);
        vec_t v;
        v.clrn = c; v.req = r; v.last = l; v.rdy = rd; v.data = d;
        v.ack = a; v.ov = ov; v.od = od; v.ol = ol; v.g = g; v.b = b;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    localparam logic [31:0] D0 = 32'h13121110;

    initial begin
        int n;
        // reset hold, round-robin singles
        vt[0]  = mk(0, 4'hF, 4'hF, 1, D0, 4'h0, 0, 8'h00, 0, 4'h0, 0);
        vt[1]  = mk(0, 4'hF, 4'hF, 1, D0, 4'h0, 0, 8'h00, 0, 4'h0, 0);
        vt[2]  = mk(0, 4'hF, 4'hF, 1, D0, 4'h0, 0, 8'h00, 0, 4'h0, 0);
        vt[3]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h1, 0, 8'h00, 0, 4'h0, 0);
        vt[4]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h2, 1, 8'h10, 1, 4'h0, 0);
        vt[5]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h4, 1, 8'h11, 1, 4'h0, 0);
        vt[6]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h8, 1, 8'h12, 1, 4'h0, 0);
        vt[7]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h1, 1, 8'h13, 1, 4'h0, 0);
        vt[8]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h2, 1, 8'h10, 1, 4'h0, 0);
        vt[9]  = mk(1, 4'hF, 4'hF, 1, D0, 4'h4, 1, 8'h11, 1, 4'h0, 0);
        vt[10] = mk(1, 4'hF, 4'hF, 1, D0, 4'h8, 1, 8'h12, 1, 4'h0, 0);
        // packet lock: requester 1 three beats, requester 2 waiting
        vt[11] = mk(1, 4'h6, 4'h0, 1, 32'h00B1A100, 4'h2, 1, 8'h13, 1, 4'h0, 0);
        vt[12] = mk(1, 4'h6, 4'h0, 1, 32'h00B1A200, 4'h2, 1, 8'hA1, 0, 4'h2, 1);
        vt[13] = mk(1, 4'h6, 4'h2, 1, 32'h00B1A300, 4'h2, 1, 8'hA2, 0, 4'h2, 1);
        vt[14] = mk(1, 4'h4, 4'h4, 1, 32'h00B10000, 4'h4, 1, 8'hA3, 1, 4'h0, 0);
        // backpressure
        vt[15] = mk(1, 4'h1, 4'h1, 0, 32'h000000C1, 4'h0, 1, 8'hB1, 1, 4'h0, 0);
        vt[16] = mk(1, 4'h1, 4'h1, 0, 32'h000000C1, 4'h0, 1, 8'hB1, 1, 4'h0, 0);
        vt[17] = mk(1, 4'h1, 4'h1, 0, 32'h000000C1, 4'h0, 1, 8'hB1, 1, 4'h0, 0);
        vt[18] = mk(1, 4'h1, 4'h1, 0, 32'h000000C1, 4'h0, 1, 8'hB1, 1, 4'h0, 0);
        vt[19] = mk(1, 4'h1, 4'h1, 0, 32'h000000C1, 4'h0, 1, 8'hB1, 1, 4'h0, 0);
        vt[20] = mk(1, 4'h1, 4'h1, 1, 32'h000000C1, 4'h1, 1, 8'hB1, 1, 4'h0, 0);
        vt[21] = mk(1, 4'h0, 4'h0, 1, 32'h00000000, 4'h0, 1, 8'hC1, 1, 4'h0, 0);
        vt[22] = mk(1, 4'h0, 4'h0, 1, 32'h00000000, 4'h0, 0, 8'hC1, 1, 4'h0, 0);
        // owner stall: requester 3 drops req mid-packet, stray last ignored
        vt[23] = mk(1, 4'h8, 4'h0, 1, 32'hD1000000, 4'h8, 0, 8'hC1, 1, 4'h0, 0);
        vt[24] = mk(1, 4'h7, 4'h0, 1, 32'h00C2B2A2, 4'h0, 1, 8'hD1, 0, 4'h8, 1);
        vt[25] = mk(1, 4'h7, 4'h8, 1, 32'h00C2B2A2, 4'h0, 0, 8'hD1, 0, 4'h8, 1);
        vt[26] = mk(1, 4'h7, 4'h0, 1, 32'h00C2B2A2, 4'h0, 0, 8'hD1, 0, 4'h8, 1);
        vt[27] = mk(1, 4'h7, 4'h0, 1, 32'h00C2B2A2, 4'h0, 0, 8'hD1, 0, 4'h8, 1);
        vt[28] = mk(1, 4'hF, 4'h8, 1, 32'hD2C2B2A2, 4'h8, 0, 8'hD1, 0, 4'h8, 1);
        // single beat from 1 moves ptr to 2, then reset mid-packet from 2
        vt[29] = mk(1, 4'h2, 4'h2, 1, 32'h0000B300, 4'h2, 1, 8'hD2, 1, 4'h0, 0);
        vt[30] = mk(1, 4'h4, 4'h0, 1, 32'h00E10000, 4'h4, 1, 8'hB3, 1, 4'h0, 0);
        vt[31] = mk(1, 4'h4, 4'h0, 1, 32'h00E20000, 4'h4, 1, 8'hE1, 0, 4'h4, 1);
        vt[32] = mk(0, 4'h4, 4'h0, 1, 32'h00E30000, 4'h0, 1, 8'hE2, 0, 4'h4, 1);
        vt[33] = mk(1, 4'hF, 4'hF, 1, D0,           4'h1, 0, 8'h00, 0, 4'h0, 0);
        vt[34] = mk(1, 4'h0, 4'h0, 1, 32'h00000000, 4'h0, 1, 8'h10, 1, 4'h0, 0);

        clrn = 1'b0; req = 4'hF; last = 4'hF; data = D0; out_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            clrn = vt[i].clrn; req = vt[i].req; last = vt[i].last;
            out_ready = vt[i].rdy; data = vt[i].data;
            #1;
            chk($sformatf("v%0d_ack", i),       32'(ack),       32'(vt[i].ack));
            chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].ov));
            chk($sformatf("v%0d_out_data", i),  32'(out_data),  32'(vt[i].od));
            chk($sformatf("v%0d_out_last", i),  32'(out_last),  32'(vt[i].ol));
            chk($sformatf("v%0d_grant", i),     32'(grant),     32'(vt[i].g));
            chk($sformatf("v%0d_busy", i),      32'(busy),      32'(vt[i].b));
        end

        // one-shot beat: bounded wait for it to appear, then exactly one output
        @(negedge clk);
        req = 4'h1; last = 4'h1; data = 32'h00000077; out_ready = 1'b1;
        #1;
        chk("seq_ack", 32'(ack), 32'h1);
        @(posedge clk);
        #1;
        req = 4'h0; last = 4'h0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("seq_latency", 32'(n), 32'd0);
        chk("seq_data", 32'(out_data), 32'h77);
        @(posedge clk);
        #1;
        chk("seq_no_dup", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
